// File: rtl/if_pipe_stage.sv
// IF->ID stage register: PC, instruction and metadata with valid/ready flow control and a one-entry skid buffer.
// Optional IF_PIPE_DIFFTEST_EN adds a registered flush flag and a saturating count of flush-dropped entries.
module if_pipe_stage #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int META_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [META_W-1:0] meta_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [META_W-1:0] meta_o
`ifdef IF_PIPE_DIFFTEST_EN
  ,
  output logic              difftest_flush_o,
  output logic [15:0]       difftest_drop_cnt_o
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [META_W-1:0] meta;
  } entry_t;

  entry_t main_q, skid_q, in_entry;
  logic   main_vld, skid_vld;
  logic   in_fire, out_fire;

  assign in_entry = '{pc: pc_i, inst: inst_i, meta: meta_i};

  // Ready comes only from the skid flag and stall, so it never combinationally follows out_ready_i.
  assign in_ready_o = ~skid_vld & ~stall_i;
  assign in_fire    = in_valid_i & in_ready_o & ~flush_i;
  assign out_fire   = main_vld & out_ready_i & ~stall_i;

  assign out_valid_o = main_vld;
  assign pc_o        = main_q.pc;
  assign inst_o      = main_q.inst;
  assign meta_o      = main_q.meta;

  always_ff @(posedge clk) begin
    // NOTE: payload registers are cleared on reset and flush too, so an empty stage always shows zeros downstream.
    if (rst || flush_i) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (!stall_i) begin
      if (!main_vld || out_fire) begin
        if (skid_vld) begin
          // NOTE: non-blocking assignment lets skid_q be read and cleared in the same edge without ordering hazards.
          main_q   <= skid_q;
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
          skid_q   <= '0;
        end else if (in_fire) begin
          main_q   <= in_entry;
          main_vld <= 1'b1;
        end else begin
          main_q   <= '0;
          main_vld <= 1'b0;
        end
      end else if (in_fire) begin
        skid_q   <= in_entry;
        skid_vld <= 1'b1;
      end
    end
  end

`ifdef IF_PIPE_DIFFTEST_EN
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, difftest_drop_cnt_o} + 17'(main_vld) + 17'(skid_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      difftest_flush_o    <= 1'b0;
      difftest_drop_cnt_o <= '0;
    end else begin
      difftest_flush_o <= flush_i;
      if (flush_i)
        difftest_drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: doc/if_pipe_stage.md
Name: if_pipe_stage

Overview:
- Parametrised, handshake-based IF->ID stage register; successor to the fixed-width flush/stall IF pipeline register.
- Carries PC, instruction and a generic metadata bundle (branch-predict bits etc.) with valid/ready flow control.
- A one-entry skid buffer lets in_ready_o be driven from a register while still sustaining full throughput.
- Sits between the fetch unit and the decoder; flush and legacy stall inputs come from the hazard/redirect logic.

Parameters:
PC_W, 64, PC width in bits
INST_W, 32, instruction width in bits
META_W, 1, metadata width in bits (>=1; bit 0 = predict_is_yes)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all held entries this cycle
stall_i  in  1  freeze stage: no accept, no issue
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept
pc_i  in  PC_W  upstream PC
inst_i  in  INST_W  upstream instruction
meta_i  in  META_W  upstream metadata
out_valid_o  out  1  downstream entry valid
out_ready_i  in  1  downstream accepts
pc_o  out  PC_W  held PC
inst_o  out  INST_W  held instruction
meta_o  out  META_W  held metadata

Behaviour:
- Storage: main register (drives outputs) with main_vld; skid register with skid_vld.
- Reset: main_vld=0, skid_vld=0, all payload regs=0, so out_valid_o=0, pc_o/inst_o/meta_o=0.
- in_ready_o = ~skid_vld & ~stall_i. It depends on a register and stall_i only, never on out_ready_i.
- in_fire = in_valid_i & in_ready_o & ~flush_i.
- out_fire = main_vld & out_ready_i & ~stall_i.
- out_valid_o = main_vld, pc_o/inst_o/meta_o = main payload. Latency is 1 cycle from in_fire to out_valid_o.
- Update priority, evaluated every cycle:
  1. rst: clear everything.
  2. flush_i: main_vld=0, skid_vld=0, all payload=0. Any simultaneous in_fire or out_fire is ignored; the input is dropped.
  3. stall_i: all state holds.
  4. Otherwise:
     - If main is empty or out_fire: main loads skid when skid_vld=1 (skid_vld goes to 0; a concurrent in_fire cannot occur because in_ready_o=0). Else main loads the input if in_fire. Else main_vld=0 and payload clears to 0.
     - If main is full and ~out_fire and in_fire: the input goes to skid, skid_vld=1.
- Throughput: 1 entry/cycle when out_ready_i stays high. At most 2 entries are held. Order is strictly FIFO.
- Full condition: skid_vld=1 forces in_ready_o=0 until main drains.
- Bubble payload is always 0, so a flushed or empty stage presents pc_o=0 and inst_o=0.
- out_valid_o may rise or stay asserted regardless of out_ready_i. Once asserted, it and the payload stay stable until out_fire or flush.

Optional Feature:
- Macro: IF_PIPE_DIFFTEST_EN.
- When defined, two extra output ports are added:
  - difftest_flush_o (1): flush_i registered one cycle, reset to 0.
  - difftest_drop_cnt_o (16): number of valid entries discarded by flushes, i.e. main_vld + skid_vld at each flush cycle. Saturates at 16'hFFFF and is cleared only by rst.
- When undefined, neither port nor its logic exists.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, pc_o=0, inst_o=0, in_ready_o=1 after release.
- Streaming: 4 back-to-back inputs pc=0x80000000..0x8000000C, out_ready_i=1 -> same PCs on out_valid_o one cycle later each, no gaps, in_ready_o stays 1.
- Backpressure: out_ready_i=0 while sending A then B -> out holds A, skid holds B, in_ready_o=0. Raise out_ready_i -> A, then B, in order; in_ready_o returns to 1 the cycle after B moves to main.
- Flush with 2 entries held plus in_valid_i=1 in the same cycle -> next cycle out_valid_o=0, pc_o=0, in_ready_o=1. With IF_PIPE_DIFFTEST_EN: difftest_flush_o=1 and difftest_drop_cnt_o increments by 2.
- Stall: stall_i=1 for 3 cycles with main full and out_ready_i=1 -> outputs unchanged, in_ready_o=0, no entry consumed. After release the entry issues once.
- Width: META_W=3, PC_W=39 build, meta_i=3'b101 -> meta_o=3'b101 after 1 cycle.
